// File: rtl/acc_step_driver_if.sv
// Bus between the step driver and its surroundings: control request/response
// plus the sel/in1/in2 accumulator operand port and the total read-back.
interface acc_step_driver_if #(
  parameter int unsigned ACC_W = 7,
  parameter int unsigned CNT_W = 5
);
  logic             start;
  logic [ACC_W-1:0] target;
  logic [ACC_W-1:0] acc_out;
  logic             acc_clr;
  logic [1:0]       sel;
  logic [2:0]       in1;
  logic [2:0]       in2;
  logic             busy;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    input  start, target, acc_out,
    output acc_clr, sel, in1, in2, busy, done, match, step_cnt
  );

  modport slave (
    output start, target, acc_out,
    input  acc_clr, sel, in1, in2, busy, done, match, step_cnt
  );
endinterface

// File: rtl/acc_step_driver.sv
// Clears the accumulator, then feeds operand steps until the total equals the
// latched target; reads the total back and reports done plus match.
module acc_step_driver #(
  parameter int unsigned ACC_W      = 7,
  parameter bit          ALLOW_PAIR = 1'b1,
  parameter int unsigned CNT_W      = 5
) (
  input logic               clk,
  input logic               rst,
  acc_step_driver_if.master bus
);

  typedef enum logic [1:0] {StIdle, StClr, StStep, StCheck} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] rem_q;
  logic [ACC_W-1:0] tq_q;
  logic             acc_clr_q;
  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic [1:0]       sel_q;
  logic [2:0]       in1_q;
  logic [2:0]       in2_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       step_sel;
  logic [2:0]       step_in1;
  logic [2:0]       step_in2;
  logic [ACC_W-1:0] step_amt;
  logic [ACC_W-1:0] rem_minus7;

  // Largest step the remainder allows: min(R,14) with pairs, min(R,7) without.
  always_comb begin
    rem_minus7 = rem_q - ACC_W'(7);
    step_sel   = 2'd2;
    step_in1   = rem_q[2:0];
    step_in2   = 3'd0;
    step_amt   = rem_q;
    if (ALLOW_PAIR && rem_q >= ACC_W'(14)) begin
      step_sel = 2'd1;
      step_in1 = 3'd7;
      step_in2 = 3'd7;
      step_amt = ACC_W'(14);
    end else if (ALLOW_PAIR && rem_q >= ACC_W'(8)) begin
      step_sel = 2'd1;
      step_in1 = 3'd7;
      step_in2 = rem_minus7[2:0];
    end else if (rem_q >= ACC_W'(7)) begin
      step_in1 = 3'd7;
      step_amt = ACC_W'(7);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      tq_q      <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      sel_q     <= 2'd0;
      in1_q     <= 3'd0;
      in2_q     <= 3'd0;
      cnt_q     <= '0;
    end else begin
      // Zero step and deasserted pulses unless a branch below says otherwise.
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= 2'd0;
      in1_q     <= 3'd0;
      in2_q     <= 3'd0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            rem_q     <= bus.target;
            tq_q      <= bus.target;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            state_q   <= StClr;
          end
        end
        StClr, StStep: begin
          if (rem_q != '0) begin
            sel_q   <= step_sel;
            in1_q   <= step_in1;
            in2_q   <= step_in2;
            rem_q   <= rem_q - step_amt;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= StStep;
          end else begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          match_q <= (bus.acc_out == tq_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.acc_clr  = acc_clr_q;
  assign bus.sel      = sel_q;
  assign bus.in1      = in1_q;
  assign bus.in2      = in2_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.match    = match_q;
  assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_acc_step_driver.sv
// Drives a pair-step and a single-step driver side by side against behavioural
// accumulators and a step-list reference model derived from target arithmetic.
module tb_acc_step_driver;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] in1;
    logic [2:0] in2;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] target;
  logic       force99;
  logic [7:0] acc_p;
  logic [7:0] acc_s;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  acc_step_driver_if #(.ACC_W(7), .CNT_W(5)) bus_p ();
  acc_step_driver_if #(.ACC_W(7), .CNT_W(5)) bus_s ();

  acc_step_driver #(.ACC_W(7), .ALLOW_PAIR(1'b1), .CNT_W(5)) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p.master)
  );
  acc_step_driver #(.ACC_W(7), .ALLOW_PAIR(1'b0), .CNT_W(5)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.master)
  );

  assign bus_p.start   = start;
  assign bus_s.start   = start;
  assign bus_p.target  = target;
  assign bus_s.target  = target;
  assign bus_p.acc_out = force99 ? 7'd99 : acc_p[6:0];
  assign bus_s.acc_out = acc_s[6:0];

  function automatic logic [7:0] step_val(input logic [1:0] s, input logic [2:0] a,
                                          input logic [2:0] b);
    case (s)
      2'd0:    return {5'd0, b};
      2'd1:    return {5'd0, a} + {5'd0, b};
      2'd2:    return {5'd0, a};
      default: return 8'd0;
    endcase
  endfunction

  // 8-bit accumulators so any overshoot past 127 stays visible.
  always @(posedge clk) begin
    if (rst || bus_p.acc_clr) acc_p <= 8'd0;
    else acc_p <= acc_p + step_val(bus_p.sel, bus_p.in1, bus_p.in2);
    if (rst || bus_s.acc_clr) acc_s <= 8'd0;
    else acc_s <= acc_s + step_val(bus_s.sel, bus_s.in1, bus_s.in2);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Next step for a remainder: take as much as the step size limit allows.
  function automatic step_t model_step(input int rem, input bit pair);
    step_t s;
    int    amt;
    amt = (rem < (pair ? 14 : 7)) ? rem : (pair ? 14 : 7);
    if (amt > 7) begin
      s.sel = 2'd1; s.in1 = 3'd7; s.in2 = 3'(amt - 7);
    end else begin
      s.sel = 2'd2; s.in1 = 3'(amt); s.in2 = 3'd0;
    end
    return s;
  endfunction

  task automatic cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input int t, input bit noise, input bit frc);
    step_t exp_p[$];
    step_t exp_s[$];
    step_t got_p[$];
    step_t got_s[$];
    step_t s;
    int    rem;
    int    done_p = -1;
    int    done_s = -1;
    rem = t;
    while (rem > 0) begin
      s = model_step(rem, 1'b1); exp_p.push_back(s);
      rem -= int'(step_val(s.sel, s.in1, s.in2));
    end
    rem = t;
    while (rem > 0) begin
      s = model_step(rem, 1'b0); exp_s.push_back(s);
      rem -= int'(step_val(s.sel, s.in1, s.in2));
    end
    force99 = frc;
    @(negedge clk);
    start = 1'b1;
    target = 7'(t);
    cycle();
    check("busy_accept", int'(bus_p.busy), 1);
    check("clr_accept", int'(bus_s.acc_clr), 1);
    start = 1'b0;
    for (int k = 1; k <= 40 && (done_p < 0 || done_s < 0); k++) begin
      if (noise && k == 2) begin start = 1'b1; target = ~7'(t); end
      if (noise && k == 3) start = 1'b0;
      cycle();
      if (k == 1) check("clr_one_cycle", int'(bus_p.acc_clr), 0);
      if (done_p >= 0 && k == done_p + 1) check("done_pulse_p", int'(bus_p.done), 0);
      if (done_p < 0 && (bus_p.in1 != 0 || bus_p.in2 != 0))
        got_p.push_back({bus_p.sel, bus_p.in1, bus_p.in2});
      if (done_s < 0 && (bus_s.in1 != 0 || bus_s.in2 != 0))
        got_s.push_back({bus_s.sel, bus_s.in1, bus_s.in2});
      if (done_p < 0 && bus_p.done) done_p = k;
      if (done_s < 0 && bus_s.done) done_s = k;
    end
    check("latency_p", done_p, exp_p.size() + 2);
    check("latency_s", done_s, exp_s.size() + 2);
    check("nsteps_p", got_p.size(), exp_p.size());
    check("nsteps_s", got_s.size(), exp_s.size());
    for (int i = 0; i < got_p.size() && i < exp_p.size(); i++)
      check($sformatf("step_p[%0d]", i), int'(got_p[i]), int'(exp_p[i]));
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++)
      check($sformatf("step_s[%0d]", i), int'(got_s[i]), int'(exp_s[i]));
    check("step_cnt_p", int'(bus_p.step_cnt), exp_p.size());
    check("step_cnt_s", int'(bus_s.step_cnt), exp_s.size());
    check("acc_total_p", int'(acc_p), t);
    check("acc_total_s", int'(acc_s), t);
    check("match_p", int'(bus_p.match), frc ? int'(t == 99) : 1);
    check("match_s", int'(bus_s.match), 1);
    cycle();
    check("idle_done_s", int'(bus_s.done), 0);
    check("idle_busy_p", int'(bus_p.busy), 0);
    check("match_held_p", int'(bus_p.match), frc ? int'(t == 99) : 1);
    force99 = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(bus_p.busy), 0);
    check({tag, "_done"}, int'(bus_p.done), 0);
    check({tag, "_match"}, int'(bus_p.match), 0);
    check({tag, "_clr"}, int'(bus_p.acc_clr), 0);
    check({tag, "_step"}, int'({bus_p.sel, bus_p.in1, bus_p.in2}), 0);
    check({tag, "_cnt"}, int'(bus_p.step_cnt), 0);
  endtask

  initial begin
    int idle_wait;
    rst = 1'b1; start = 1'b0; target = 7'd0; force99 = 1'b0;
    #1;
    check_zero("reset");
    #20;
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 1'b0, 1'b0);
    run_op(10, 1'b0, 1'b0);
    run_op(100, 1'b0, 1'b0);
    run_op(127, 1'b0, 1'b0);
    run_op(20, 1'b0, 1'b0);
    run_op(45, 1'b1, 1'b0);
    run_op(100, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      run_op(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b0);

    // Held start: pair driver (T=10) re-accepts on the cycle after done.
    @(negedge clk);
    start = 1'b1; target = 7'd10;
    for (int k = 0; k <= 4; k++) begin
      cycle();
      if (k == 3) check("hold_done", int'(bus_p.done), 1);
      if (k == 4) begin
        check("hold_rebusy", int'(bus_p.busy), 1);
        check("hold_reclr", int'(bus_p.acc_clr), 1);
      end
    end
    start = 1'b0;
    idle_wait = 0;
    while ((bus_p.busy || bus_s.busy) && idle_wait < 60) begin
      cycle();
      idle_wait++;
    end
    check("hold_drain", int'(bus_p.busy | bus_s.busy), 0);

    // Asynchronous reset in the middle of a long operation.
    @(negedge clk);
    start = 1'b1; target = 7'd100;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle();
    check("pre_rst_busy", int'(bus_p.busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    cycle();
    check("midrst_hold_done", int'(bus_p.done | bus_s.done), 0);
    rst = 1'b0;
    cycle();
    check("post_rst_busy", int'(bus_p.busy | bus_s.busy), 0);
    run_op(33, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
